// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} fetch_state_t;

    typedef enum logic [1:0] {ERR_NONE, ERR_MISALIGN, ERR_MEM, ERR_TIMEOUT} fetch_err_t;

    localparam int unsigned INSTR_BYTES = 4;

    function automatic logic misaligned(input logic [0:63] addr);
        logic [63:0] a;
        a = addr;
        return (a & 64'(INSTR_BYTES - 1)) != '0;
    endfunction

    // 32-bit mode clears the upper address word (bits 0..31, bit 0 = MSB)
    function automatic logic [0:63] mask_addr(input logic [0:63] addr, input logic mode_32b);
        return mode_32b ? {32'h0, addr[32:63]} : addr;
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// Output register for a fetched instruction: word, address, error and valid,
// loaded by the fetch FSM and released by consume or flush.
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load,
    input  logic [0:31] i_instr,
    input  logic [0:63] i_addr,
    input  fetch_err_t  i_err,
    input  logic        i_consume,
    input  logic        i_clear,
    output logic [0:31] o_instr,
    output logic [0:63] o_addr,
    output fetch_err_t  o_err,
    output logic        o_valid
);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_instr <= '0;
            o_addr  <= '0;
            o_err   <= ERR_NONE;
            o_valid <= 1'b0;
        end else if (i_load) begin
            o_instr <= i_instr;
            o_addr  <= i_addr;
            o_err   <= i_err;
            o_valid <= 1'b1;
        end else if (i_consume || i_clear) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: single-outstanding request to instruction memory,
// holds the returned word until instruction identify accepts it.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [0:63] RESET_ADDR     = 64'h0,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_32b_mode,
    input  logic [0:63] i_next_instr_addr,
    output logic        o_stall,
    input  logic        i_flush,
    input  logic [0:63] i_flush_addr,
    output logic        o_mem_req,
    output logic [0:63] o_mem_addr,
    input  logic        i_mem_gnt,
    input  logic        i_mem_rsp_valid,
    input  logic [0:31] i_mem_rsp_data,
    input  logic        i_mem_rsp_err,
    output logic [0:31] o_instr,
    output logic        o_instr_valid,
    input  logic        i_instr_ready,
    output logic [0:63] o_instr_addr,
    output logic        o_fetch_err,
    output logic [0:1]  o_err_code
);

    fetch_state_t state_q, state_d;
    logic [0:63]  fetch_addr_q, fetch_addr_d;
    logic         drop_q, drop_d;
    logic [7:0]   timer_q, timer_d;
    logic         timeout;

    logic         hb_load, hb_consume, hb_clear;
    logic [0:31]  hb_instr;
    fetch_err_t   hb_err_d, hb_err_q;

    assign timeout    = (timer_q == 8'(TIMEOUT_CYCLES - 1));
    assign o_mem_addr = mask_addr(fetch_addr_q, i_32b_mode);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= BOOT;
            fetch_addr_q <= '0;
            drop_q       <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            drop_q       <= drop_d;
            timer_q      <= timer_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        drop_d       = drop_q;
        timer_d      = timer_q;
        o_mem_req    = 1'b0;
        o_stall      = 1'b1;
        hb_load      = 1'b0;
        hb_consume   = 1'b0;
        hb_clear     = 1'b0;
        hb_instr     = '0;
        hb_err_d     = ERR_NONE;

        // a late response to a timed-out request can land outside WAIT
        if (drop_q && i_mem_rsp_valid && state_q != WAIT)
            drop_d = 1'b0;

        unique case (state_q)
            BOOT: begin
                fetch_addr_d = i_flush ? i_flush_addr : RESET_ADDR;
                state_d      = REQ;
            end
            REQ: begin
                if (misaligned(fetch_addr_q)) begin
                    if (i_flush) begin
                        fetch_addr_d = i_flush_addr;
                    end else begin
                        hb_load  = 1'b1;
                        hb_err_d = ERR_MISALIGN;
                        state_d  = HOLD;
                    end
                end else begin
                    o_mem_req = 1'b1;
                    if (i_flush)
                        fetch_addr_d = i_flush_addr;
                    if (i_mem_gnt) begin
                        state_d = WAIT;
                        timer_d = '0;
                        if (i_flush)
                            drop_d = 1'b1;
                    end
                end
            end
            WAIT: begin
                timer_d = timer_q + 8'd1;
                if (i_flush) begin
                    fetch_addr_d = i_flush_addr;
                    // a response in the flush cycle is the outstanding one: nothing left to drop
                    if (i_mem_rsp_valid) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        drop_d = 1'b1;
                        if (timeout)
                            state_d = REQ;
                    end
                end else if (i_mem_rsp_valid) begin
                    if (drop_q) begin
                        drop_d  = 1'b0;
                        state_d = REQ;
                    end else begin
                        hb_load  = 1'b1;
                        hb_instr = i_mem_rsp_data;
                        hb_err_d = i_mem_rsp_err ? ERR_MEM : ERR_NONE;
                        state_d  = HOLD;
                    end
                end else if (timeout) begin
                    hb_load  = 1'b1;
                    hb_err_d = ERR_TIMEOUT;
                    drop_d   = 1'b1;
                    state_d  = HOLD;
                end
            end
            HOLD: begin
                if (i_flush) begin
                    hb_clear     = 1'b1;
                    fetch_addr_d = i_flush_addr;
                    state_d      = REQ;
                end else if (i_instr_ready) begin
                    hb_consume   = 1'b1;
                    o_stall      = 1'b0;
                    fetch_addr_d = i_next_instr_addr;
                    state_d      = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    fetch_hold_buf u_hold_buf (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .i_load    (hb_load),
        .i_instr   (hb_instr),
        .i_addr    (fetch_addr_q),
        .i_err     (hb_err_d),
        .i_consume (hb_consume),
        .i_clear   (hb_clear),
        .o_instr   (o_instr),
        .o_addr    (o_instr_addr),
        .o_err     (hb_err_q),
        .o_valid   (o_instr_valid)
    );

    assign o_err_code  = hb_err_q;
    assign o_fetch_err = o_instr_valid && (hb_err_q != ERR_NONE);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus a
// randomized run against a transaction-level model of the fetch stream.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

    localparam int unsigned TIMEOUT = 255;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_32b_mode = 1'b0;
    logic [63:0] i_next_instr_addr = '0;
    logic        o_stall;
    logic        i_flush = 1'b0;
    logic [63:0] i_flush_addr = '0;
    logic        o_mem_req;
    logic [63:0] o_mem_addr;
    logic        i_mem_gnt = 1'b0;
    logic        i_mem_rsp_valid = 1'b0;
    logic [31:0] i_mem_rsp_data = '0;
    logic        i_mem_rsp_err = 1'b0;
    logic [31:0] o_instr;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [63:0] o_instr_addr;
    logic        o_fetch_err;
    logic [1:0]  o_err_code;

    always #5 i_clk = ~i_clk;

    instr_fetch_unit #(
        .RESET_ADDR     (64'h0),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .i_clk             (i_clk),
        .i_rst_n           (i_rst_n),
        .i_32b_mode        (i_32b_mode),
        .i_next_instr_addr (i_next_instr_addr),
        .o_stall           (o_stall),
        .i_flush           (i_flush),
        .i_flush_addr      (i_flush_addr),
        .o_mem_req         (o_mem_req),
        .o_mem_addr        (o_mem_addr),
        .i_mem_gnt         (i_mem_gnt),
        .i_mem_rsp_valid   (i_mem_rsp_valid),
        .i_mem_rsp_data    (i_mem_rsp_data),
        .i_mem_rsp_err     (i_mem_rsp_err),
        .o_instr           (o_instr),
        .o_instr_valid     (o_instr_valid),
        .i_instr_ready     (i_instr_ready),
        .o_instr_addr      (o_instr_addr),
        .o_fetch_err       (o_fetch_err),
        .o_err_code        (o_err_code)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // memory model configuration and state
    int unsigned gnt_delay_cfg = 0;
    int unsigned rsp_lat_cfg   = 1;
    logic        rsp_err_cfg   = 1'b0;
    logic        mem_silent    = 1'b0;
    int unsigned gnt_wait      = 0;
    int unsigned rsp_cnt       = 0;
    logic [63:0] rsp_addr      = '0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0)
            return 32'h4800_0010;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [63:0] masked(input logic [63:0] a, input logic m);
        return m ? {32'h0, a[31:0]} : a;
    endfunction

    task automatic mem_step();
        i_mem_gnt       = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_err   = 1'b0;
        i_mem_rsp_data  = '0;
        if (rsp_cnt != 0) begin
            rsp_cnt--;
            if (rsp_cnt == 0) begin
                i_mem_rsp_valid = 1'b1;
                i_mem_rsp_data  = mem_word(rsp_addr);
                i_mem_rsp_err   = rsp_err_cfg;
            end
        end
        if (o_mem_req) begin
            if (gnt_wait >= gnt_delay_cfg) begin
                i_mem_gnt = 1'b1;
                gnt_wait  = 0;
                rsp_addr  = o_mem_addr;
                if (!mem_silent)
                    rsp_cnt = rsp_lat_cfg;
            end else begin
                gnt_wait++;
            end
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
        mem_step();
    endtask

    task automatic wait_valid(input string tag, input int unsigned bound);
        for (int unsigned i = 0; i < bound && !o_instr_valid; i++)
            tick();
        check_eq(tag, o_instr_valid, 1'b1);
    endtask

    task automatic accept(input logic [63:0] nxt);
        i_instr_ready     = 1'b1;
        i_next_instr_addr = nxt;
        #1;
        check_eq("accept_stall", o_stall, 1'b0);
        tick();
        i_instr_ready = 1'b0;
    endtask

    initial begin
        logic [63:0] exp_addr, nxt, exp_instr;
        logic [1:0]  exp_err;
        logic        exp_mode, exp_mem_err;
        int unsigned n_acc;

        repeat (2) tick();
        check_eq("rst_mem_req", o_mem_req, 1'b0);
        check_eq("rst_valid", o_instr_valid, 1'b0);
        check_eq("rst_instr", o_instr, 32'h0);
        check_eq("rst_instr_addr", o_instr_addr, 64'h0);
        check_eq("rst_fetch_err", o_fetch_err, 1'b0);
        check_eq("rst_err_code", o_err_code, 2'b00);
        check_eq("rst_stall", o_stall, 1'b1);

        // first fetch: valid three cycles after reset release
        i_rst_n = 1'b1;
        tick();
        check_eq("boot_req", o_mem_req, 1'b1);
        check_eq("boot_addr", o_mem_addr, 64'h0);
        check_eq("boot_valid_c1", o_instr_valid, 1'b0);
        tick();
        check_eq("boot_valid_c2", o_instr_valid, 1'b0);
        tick();
        check_eq("boot_valid_c3", o_instr_valid, 1'b1);
        check_eq("boot_instr", o_instr, 32'h4800_0010);
        check_eq("boot_instr_addr", o_instr_addr, 64'h0);
        check_eq("boot_err", o_err_code, 2'b00);

        // back-pressure then accept
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_stall", o_stall, 1'b1);
            check_eq("bp_valid", o_instr_valid, 1'b1);
        end
        accept(64'h4);
        check_eq("bp_valid_clear", o_instr_valid, 1'b0);
        check_eq("bp_next_req", o_mem_req, 1'b1);
        check_eq("bp_next_addr", o_mem_addr, 64'h4);
        wait_valid("bp_next_valid", 10);
        check_eq("bp_next_instr", o_instr, mem_word(64'h4));
        check_eq("bp_next_iaddr", o_instr_addr, 64'h4);

        // flush during WAIT; the old response must be discarded
        rsp_lat_cfg = 3;
        accept(64'h8);
        tick();
        i_flush      = 1'b1;
        i_flush_addr = 64'h100;
        #1;
        check_eq("flw_stall", o_stall, 1'b1);
        tick();
        i_flush = 1'b0;
        for (int i = 0; i < 10 && !o_mem_req; i++) begin
            check_eq("flw_no_valid", o_instr_valid, 1'b0);
            tick();
        end
        check_eq("flw_req", o_mem_req, 1'b1);
        check_eq("flw_addr", o_mem_addr, 64'h100);
        wait_valid("flw_valid", 20);
        check_eq("flw_instr", o_instr, mem_word(64'h100));
        check_eq("flw_iaddr", o_instr_addr, 64'h100);

        // flush during HOLD wins over a same-cycle ready
        rsp_lat_cfg       = 1;
        i_flush           = 1'b1;
        i_flush_addr      = 64'h200;
        i_instr_ready     = 1'b1;
        i_next_instr_addr = 64'h300;
        #1;
        check_eq("flh_stall", o_stall, 1'b1);
        tick();
        i_flush       = 1'b0;
        i_instr_ready = 1'b0;
        check_eq("flh_valid_clear", o_instr_valid, 1'b0);
        check_eq("flh_addr", o_mem_addr, 64'h200);
        wait_valid("flh_valid", 10);
        check_eq("flh_iaddr", o_instr_addr, 64'h200);
        check_eq("flh_instr", o_instr, mem_word(64'h200));

        // misaligned target: no request, error 01
        accept(64'h6);
        check_eq("mis_no_req", o_mem_req, 1'b0);
        check_eq("mis_valid_c1", o_instr_valid, 1'b0);
        tick();
        check_eq("mis_no_req2", o_mem_req, 1'b0);
        check_eq("mis_valid", o_instr_valid, 1'b1);
        check_eq("mis_fetch_err", o_fetch_err, 1'b1);
        check_eq("mis_code", o_err_code, 2'b01);
        check_eq("mis_iaddr", o_instr_addr, 64'h6);
        check_eq("mis_instr", o_instr, 32'h0);

        // 32-bit mode masks the upper address word on the memory side only
        i_32b_mode = 1'b1;
        accept(64'hFFFF_FFFF_0000_0010);
        check_eq("m32_req", o_mem_req, 1'b1);
        check_eq("m32_addr", o_mem_addr, 64'h0000_0000_0000_0010);
        wait_valid("m32_valid", 10);
        check_eq("m32_iaddr", o_instr_addr, 64'hFFFF_FFFF_0000_0010);
        check_eq("m32_instr", o_instr, mem_word(64'h10));
        i_32b_mode = 1'b0;

        // watchdog: grant, no response for TIMEOUT WAIT cycles
        mem_silent = 1'b1;
        accept(64'h20);
        check_eq("to_req", o_mem_req, 1'b1);
        repeat (TIMEOUT) tick();
        check_eq("to_valid_early", o_instr_valid, 1'b0);
        tick();
        check_eq("to_valid", o_instr_valid, 1'b1);
        check_eq("to_code", o_err_code, 2'b11);
        check_eq("to_fetch_err", o_fetch_err, 1'b1);
        check_eq("to_instr", o_instr, 32'h0);
        check_eq("to_iaddr", o_instr_addr, 64'h20);
        repeat (300 - TIMEOUT - 1) tick();
        i_mem_rsp_valid = 1'b1;
        i_mem_rsp_data  = 32'hDEAD_BEEF;
        tick();
        tick();
        check_eq("late_instr", o_instr, 32'h0);
        check_eq("late_code", o_err_code, 2'b11);
        check_eq("late_valid", o_instr_valid, 1'b1);
        mem_silent = 1'b0;
        accept(64'h24);
        wait_valid("post_to_valid", 10);
        check_eq("post_to_instr", o_instr, mem_word(64'h24));
        check_eq("post_to_code", o_err_code, 2'b00);

        // randomized stream against a transaction-level model
        exp_addr    = 64'h24;
        exp_mode    = 1'b0;
        exp_mem_err = 1'b0;
        n_acc       = 0;
        for (int unsigned cyc = 0; cyc < 4000; cyc++) begin
            i_instr_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 7))
                0:       nxt = {$urandom, $urandom & 32'hFFFF_FFFC} | 64'($urandom_range(1, 3));
                1, 2:    nxt = {$urandom, $urandom & 32'hFFFF_FFFC};
                default: nxt = {32'h0, $urandom & 32'h0000_FFFC};
            endcase
            i_next_instr_addr = nxt;
            #1;
            check_eq("rnd_stall", o_stall, !(o_instr_valid && i_instr_ready));
            if (i_mem_gnt)
                check_eq("rnd_gnt_addr", o_mem_addr, masked(exp_addr, exp_mode));
            if (o_instr_valid && i_instr_ready) begin
                if (exp_addr[1:0] != 2'b00) begin
                    exp_err   = 2'b01;
                    exp_instr = '0;
                end else begin
                    exp_err   = exp_mem_err ? 2'b10 : 2'b00;
                    exp_instr = 64'(mem_word(masked(exp_addr, exp_mode)));
                end
                check_eq("rnd_instr", o_instr, exp_instr);
                check_eq("rnd_iaddr", o_instr_addr, exp_addr);
                check_eq("rnd_code", o_err_code, exp_err);
                check_eq("rnd_fetch_err", o_fetch_err, exp_err != 2'b00);
                exp_addr      = nxt;
                exp_mode      = 1'($urandom_range(0, 1));
                exp_mem_err   = ($urandom_range(0, 5) == 0);
                i_32b_mode    = exp_mode;
                rsp_err_cfg   = exp_mem_err;
                gnt_delay_cfg = $urandom_range(0, 3);
                rsp_lat_cfg   = $urandom_range(1, 4);
                n_acc++;
            end
            tick();
        end
        i_instr_ready = 1'b0;
        check_eq("rnd_progress", n_acc > 200, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
